// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: stage tags, forwarding encodings and register compare.
// The tag structs are sized by REG_ADDR_W here; override it together with the top parameter.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regWrite;
    logic                  memToReg;
    logic                  multi;
  } e_tag_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  regWrite;
    logic                  memToReg;
  } m_tag_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  regWrite;
  } w_tag_t;

  // Register 0 is hardwired zero, so it never produces a dependency.
  function automatic logic regMatch(input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mc_busy_counter.sv
// Countdown for a multi-cycle EX op: loads MUL_LAT-1 when the op enters E, busy while non-zero.
module mc_busy_counter #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;

  always_comb begin
    cntNext = cnt;
    if (start && (MUL_LAT > 32'd1)) begin
      cntNext = CW'(MUL_LAT - 1);
    end else if (cnt != '0) begin
      cntNext = cnt - CW'(1);
    end
  end

  // busy is kept as its own flop so it leaves this block registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cntNext;
      busy <= (cntNext != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline with its own E/M/W tag pipeline and multi-cycle EX support.
// Optional perf counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned MUL_LAT    = 4
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] DstD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MultiD,
  input  logic                  BranchD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushE,
  output logic                  HoldE,
  output logic                  BubbleM,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  RegWriteW
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    LwStallCnt
  , output logic [CNT_W-1:0]    BrStallCnt
  , output logic [CNT_W-1:0]    BusyCnt
`endif
);

  import hazard_pkg::*;

  localparam int unsigned TAG_W = hazard_pkg::REG_ADDR_W;

  e_tag_t dTag;
  e_tag_t eTag;
  m_tag_t mTag;
  w_tag_t wTag;

  logic busyCnt;
  logic exBusy;
  logic lwStall;
  logic branchStall;
  logic start;

  always_comb begin
    dTag          = '0;
    dTag.rs       = TAG_W'(RsD);
    dTag.rt       = TAG_W'(RtD);
    dTag.dst      = TAG_W'(DstD);
    dTag.regWrite = RegWriteD;
    dTag.memToReg = MemtoRegD;
    dTag.multi    = MultiD;
  end

  // The counter only runs while a multi-cycle op sits in E.
  assign exBusy = busyCnt & eTag.multi;

  assign lwStall = eTag.memToReg &
                   (regMatch(dTag.rs, eTag.dst) | regMatch(dTag.rt, eTag.dst));

  assign branchStall = BranchD &
    ((eTag.regWrite & (regMatch(dTag.rs, eTag.dst) | regMatch(dTag.rt, eTag.dst))) |
     (mTag.memToReg & (regMatch(dTag.rs, mTag.dst) | regMatch(dTag.rt, mTag.dst))));

  // A busy EX wins over load-use and branch stalls.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushE  = 1'b0;
    HoldE   = 1'b0;
    BubbleM = 1'b0;
    if (exBusy) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      HoldE   = 1'b1;
      BubbleM = 1'b1;
    end else if (lwStall || branchStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // M has priority over W for the ALU operands.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (mTag.regWrite && regMatch(eTag.rs, mTag.dst))      ForwardAE = FWD_M;
    else if (wTag.regWrite && regMatch(eTag.rs, wTag.dst)) ForwardAE = FWD_W;
    if (mTag.regWrite && regMatch(eTag.rt, mTag.dst))      ForwardBE = FWD_M;
    else if (wTag.regWrite && regMatch(eTag.rt, wTag.dst)) ForwardBE = FWD_W;
  end

  assign ForwardAD = mTag.regWrite & regMatch(dTag.rs, mTag.dst);
  assign ForwardBD = mTag.regWrite & regMatch(dTag.rt, mTag.dst);
  assign WriteRegW = REG_ADDR_W'(wTag.dst);
  assign RegWriteW = wTag.regWrite;

  assign start = !exBusy && !FlushE && MultiD;

  mc_busy_counter #(
    .MUL_LAT(MUL_LAT)
  ) u_busy (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .busy (busyCnt)
  );

  // Tag pipeline: E holds while busy, M takes bubbles while busy, W always follows M.
  always_ff @(posedge clk) begin
    if (reset) begin
      eTag <= '0;
      mTag <= '0;
      wTag <= '0;
    end else begin
      wTag.dst      <= mTag.dst;
      wTag.regWrite <= mTag.regWrite;
      if (exBusy) begin
        mTag <= '0;
      end else begin
        mTag.dst      <= eTag.dst;
        mTag.regWrite <= eTag.regWrite;
        mTag.memToReg <= eTag.memToReg;
        eTag          <= FlushE ? '0 : dTag;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Each counter charges only the winning stall reason and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      LwStallCnt <= '0;
      BrStallCnt <= '0;
      BusyCnt    <= '0;
    end else if (exBusy) begin
      if (BusyCnt != '1) BusyCnt <= BusyCnt + CNT_W'(1);
    end else if (lwStall) begin
      if (LwStallCnt != '1) LwStallCnt <= LwStallCnt + CNT_W'(1);
    end else if (branchStall) begin
      if (BrStallCnt != '1) BrStallCnt <= BrStallCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (MUL_LAT=4), plus busy-length and perf sequences.
module tb_hazard_scoreboard;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [3:0]  ctl;
    logic        rst;
    logic [16:0] exp;
  } vec_t;

  localparam int RW = 'b1000;
  localparam int LD = 'b1100;
  localparam int MU = 'b1010;
  localparam int BR = 'b0001;
  localparam int ST = 'b11100;
  localparam int BZ = 'b11011;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;
  int   busyCycles;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, DstD;
  logic       RegWriteD, MemtoRegD, MultiD, BranchD;
  logic       StallF, StallD, FlushE, HoldE, BubbleM, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic [4:0] WriteRegW;
  logic       RegWriteW;
`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] LwStallCnt, BrStallCnt, BusyCnt;
`endif

  logic [16:0] act;
  assign act = {StallF, StallD, FlushE, HoldE, BubbleM, ForwardAD, ForwardBD,
                ForwardAE, ForwardBE, WriteRegW, RegWriteW};

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .MUL_LAT(4)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .DstD(DstD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MultiD(MultiD), .BranchD(BranchD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .HoldE(HoldE), .BubbleM(BubbleM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW)
`ifdef HAZARD_PERF_CNT_EN
    , .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt), .BusyCnt(BusyCnt)
`endif
  );

  task automatic av(input int rs, input int rt, input int dst, input int ctl, input int rst,
                    input int stl, input int fd, input int fae, input int fbe,
                    input int wreg, input int rww);
    vec_t v;
    v.rs  = 5'(rs);
    v.rt  = 5'(rt);
    v.dst = 5'(dst);
    v.ctl = 4'(ctl);
    v.rst = 1'(rst);
    v.exp = {5'(stl), 2'(fd), 2'(fae), 2'(fbe), 5'(wreg), 1'(rww)};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic [3:0] ctl, input logic rst);
    RsD = rs;
    RtD = rt;
    DstD = dst;
    {RegWriteD, MemtoRegD, MultiD, BranchD} = ctl;
    reset = rst;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 1);
    tick();

    // rs rt dst ctl rst | stall fwdD fAE fBE wreg rww
    av(3, 4, 5, 'b1101, 1,  0, 0, 0, 0, 0, 0);   // post-reset: zero for any D
    av(1, 2, 3, RW, 0,  0, 0, 0, 0, 0, 0);       // add $3
    av(3, 3, 4, RW, 0,  0, 0, 0, 0, 0, 0);       // add $4,$3,$3
    av(3, 0, 6, RW, 0,  0, 'b10, 2, 2, 0, 0);    // dependent add in E, $3 in M
    av(0, 0, 0, RW, 0,  0, 0, 1, 0, 3, 1);       // two behind: from W
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 1);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 6, 1);       // dst $0 in M never forwards
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    av(1, 0, 5, LD, 0,  0, 0, 0, 0, 0, 0);       // lw $5
    av(5, 0, 8, RW, 0,  ST, 0, 0, 0, 0, 0);      // load-use stall
    av(5, 0, 8, RW, 0,  0, 'b10, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0,   0, 0, 1, 0, 5, 1);       // loaded value from W
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 8, 1);
    av(1, 2, 7, RW, 0,  0, 0, 0, 0, 0, 0);       // add $7
    av(7, 0, 0, BR, 0,  ST, 0, 0, 0, 0, 0);      // branch after ALU write
    av(7, 0, 0, BR, 0,  0, 'b10, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0,   0, 0, 1, 0, 7, 1);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    av(1, 0, 7, LD, 0,  0, 0, 0, 0, 0, 0);       // lw $7
    av(7, 0, 0, BR, 0,  ST, 0, 0, 0, 0, 0);      // branch after load: 2 stalls
    av(7, 0, 0, BR, 0,  ST, 'b10, 0, 0, 0, 0);
    av(7, 0, 0, BR, 0,  0, 0, 0, 0, 7, 1);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    av(1, 2, 9, MU, 0,  0, 0, 0, 0, 0, 0);       // mult $9
    av(9, 0, 10, RW, 0, BZ, 0, 0, 0, 0, 0);
    av(9, 0, 10, RW, 0, BZ, 0, 0, 0, 0, 0);
    av(9, 0, 10, RW, 0, BZ, 0, 0, 0, 0, 0);
    av(9, 0, 10, RW, 0, 0, 0, 0, 0, 0, 0);       // mult's last EX cycle
    av(0, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0);       // mult in M forwards to add
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 9, 1);
    av(0, 0, 0, 0, 0,   0, 0, 0, 0, 10, 1);
    av(1, 2, 11, MU, 0, 0, 0, 0, 0, 0, 0);       // back-to-back mults
    av(3, 4, 12, MU, 0, BZ, 0, 0, 0, 0, 0);
    av(3, 4, 12, MU, 0, BZ, 0, 0, 0, 0, 0);
    av(3, 4, 12, MU, 0, BZ, 0, 0, 0, 0, 0);
    av(3, 4, 12, MU, 0, 0, 0, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0,   BZ, 0, 0, 0, 0, 0);      // second mult reloaded
    av(0, 0, 0, 0, 1,   BZ, 0, 0, 0, 11, 1);     // reset while cnt=2
    av(3, 4, 5, 'b1111, 0, 0, 0, 0, 0, 0, 0);    // all clear, counter idle
    av(0, 0, 0, 0, 1,   BZ, 0, 0, 0, 0, 0);      // that mult restarted the count

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].ctl, vecs[i].rst);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
      tick();
    end

    // Busy window length for one mult, bounded wait.
    drive(0, 0, 0, 0, 1);
    tick();
    drive(1, 2, 9, 4'(MU), 0);
    tick();
    drive(0, 0, 0, 0, 0);
    busyCycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!HoldE) break;
      busyCycles++;
      tick();
    end
    check("busy_cycles", 32'(busyCycles), 32'd3);

`ifdef HAZARD_PERF_CNT_EN
    drive(0, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 5, 4'(LD), 0);
      tick();
      drive(5, 0, 8, 4'(RW), 0);
      tick();
      tick();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("lw_stall_cnt", 32'(LwStallCnt), 32'd3);
    check("br_stall_cnt", 32'(BrStallCnt), 32'd0);
    check("busy_cnt", 32'(BusyCnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
